// File: rtl/regfile_pkg.sv
// Register-file constants shared by the write arbiter and its index decoder.
// Holds the register count, the index and data widths, and the one-hot helper.
package regfile_pkg;

  localparam int NUM_REGS  = 16;
  localparam int REG_IDX_W = 4;
  localparam int DATA_W    = 32;
  localparam int ID_W      = 3;

  localparam logic [REG_IDX_W-1:0] REG_R0 = 4'd0;

  function automatic logic [NUM_REGS-1:0] onehot16(input logic [REG_IDX_W-1:0] idx);
    onehot16 = 16'h0001 << idx;
  endfunction

endpackage

// File: rtl/decoder_4_to_16.sv
// Turns a 4-bit register index into a one-hot enable; zero output when en is low.
// Purely combinational, zero latency, no backpressure.
module decoder_4_to_16 (
  input  logic [3:0]  idx,
  input  logic        en,
  output logic [15:0] dec
);
  import regfile_pkg::*;

  assign dec = en ? onehot16(idx) : 16'h0000;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin share of the register-file write port; one registered cycle to wr_en/wr_data.
// Backpressure: req_ready is the combinational grant, forced low by stall or clear.
module regfile_write_arbiter #(
  parameter int N_REQ       = 3,
  parameter int DATA_W      = regfile_pkg::DATA_W,
  parameter bit R0_WRITABLE = 1'b0
) (
  input  logic                      clock,
  input  logic                      clear,
  input  logic                      stall,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [4*N_REQ-1:0]        req_addr,
  input  logic [DATA_W*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [15:0]               wr_en,
  output logic [DATA_W-1:0]         wr_data,
  output logic                      wr_valid,
  output logic [2:0]                grant_id
);
  import regfile_pkg::*;

  logic [ID_W-1:0]      ptr;
  logic [2*N_REQ-1:0]   dbl;
  logic [N_REQ-1:0]     rot;
  logic                 hit;
  int                   gi;
  logic [N_REQ-1:0]     grant_oh;
  logic                 xfer;
  logic [ID_W-1:0]      gid;
  logic [ID_W-1:0]      ptr_nxt;
  logic [REG_IDX_W-1:0] sel_addr;
  logic [DATA_W-1:0]    sel_data;
  logic                 sel_enable;
  logic [REG_IDX_W-1:0] wr_idx;

  // Rotate the valid vector so bit 0 is the requester at ptr, then take the first set bit.
  always_comb begin
    dbl = {req_valid, req_valid} >> ptr;
    rot = dbl[N_REQ-1:0];
    hit = 1'b0;
    gi  = 0;
    for (int j = 0; j < N_REQ; j++) begin
      if (!hit && rot[j]) begin
        hit = 1'b1;
        gi  = int'(ptr) + j;
        if (gi >= N_REQ) gi = gi - N_REQ;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant_oh[i] = hit && (gi == i);
    end
  end

  assign req_ready = (clear || stall) ? '0 : grant_oh;
  assign xfer      = |(req_valid & req_ready);
  assign gid       = ID_W'(gi);
  assign ptr_nxt   = (gi + 1 >= N_REQ) ? '0 : ID_W'(gi + 1);

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_oh[i]) begin
        sel_addr = req_addr[4*i +: 4];
        sel_data = req_data[DATA_W*i +: DATA_W];
      end
    end
  end

  // An R0 write is still consumed so its requester is not starved, it just never enables.
  assign sel_enable = R0_WRITABLE || (sel_addr != REG_R0);

  always_ff @(posedge clock) begin
    if (clear) begin
      ptr      <= '0;
      wr_idx   <= '0;
      wr_data  <= '0;
      wr_valid <= 1'b0;
      grant_id <= '0;
    end else if (xfer) begin
      ptr      <= ptr_nxt;
      wr_idx   <= sel_addr;
      wr_data  <= sel_data;
      wr_valid <= sel_enable;
      grant_id <= gid;
    end else begin
      wr_idx   <= '0;
      wr_data  <= '0;
      wr_valid <= 1'b0;
      grant_id <= '0;
    end
  end

  decoder_4_to_16 u_dec (
    .idx (wr_idx),
    .en  (wr_valid),
    .dec (wr_en)
  );

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: two instances differing only in R0_WRITABLE share one stimulus stream.
module tb_regfile_write_arbiter;

  logic        clock;
  logic        clear;
  logic        stall;
  logic [2:0]  req_valid;
  logic [11:0] req_addr;
  logic [95:0] req_data;

  logic [2:0]  rdy0, rdy1;
  logic [15:0] en0, en1;
  logic [31:0] dat0, dat1;
  logic        vld0, vld1;
  logic [2:0]  gid0, gid1;

  int n_checks = 0;
  int n_errors = 0;

  regfile_write_arbiter #(.N_REQ(3), .DATA_W(32), .R0_WRITABLE(1'b0)) dut0 (
    .clock(clock), .clear(clear), .stall(stall),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(rdy0), .wr_en(en0), .wr_data(dat0), .wr_valid(vld0), .grant_id(gid0)
  );

  regfile_write_arbiter #(.N_REQ(3), .DATA_W(32), .R0_WRITABLE(1'b1)) dut1 (
    .clock(clock), .clear(clear), .stall(stall),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
    .req_ready(rdy1), .wr_en(en1), .wr_data(dat1), .wr_valid(vld1), .grant_id(gid1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  logic [15:0] exp_en [3];

  initial begin
    exp_en[0] = 16'h0008;
    exp_en[1] = 16'h0010;
    exp_en[2] = 16'h0080;

    clear     = 1'b1;
    stall     = 1'b0;
    req_valid = 3'b111;
    req_addr  = {4'd7, 4'd4, 4'd3};
    req_data  = {32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};

    // Reset: no ready while clear is high, registered outputs zero.
    #1 check("rst_rdy_t0", 64'(rdy0), 64'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clock); #1;
      check("rst_rdy", 64'(rdy0), 64'd0);
      check("rst_wr_en", 64'(en0), 64'd0);
      check("rst_grant", 64'(gid0), 64'd0);
      check("rst_wr_valid", 64'(vld0), 64'd0);
    end

    // All three valid: rotation 0,1,2 with no idle cycle.
    @(negedge clock); clear = 1'b0; #1;
    check("rr_rdy_first", 64'(rdy0), 64'b001);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock); #1;
      check("rr_wr_en", 64'(en0), 64'(exp_en[i % 3]));
      check("rr_grant", 64'(gid0), 64'(i % 3));
      check("rr_wr_valid", 64'(vld0), 64'd1);
      check("rr_rdy", 64'(rdy0), 64'(3'b001 << ((i + 1) % 3)));
    end

    // Single requester 1, addr 5.
    @(negedge clock);
    req_valid = 3'b010;
    req_addr[7:4] = 4'd5;
    req_data[63:32] = 32'hDEAD_BEEF;
    #1 check("single_rdy", 64'(rdy0), 64'b010);
    @(negedge clock); req_valid = 3'b000; #1;
    check("single_wr_en", 64'(en0), 64'h0020);
    check("single_wr_data", 64'(dat0), 64'hDEAD_BEEF);
    check("single_grant", 64'(gid0), 64'd1);
    check("single_wr_valid", 64'(vld0), 64'd1);

    // R0 write: consumed, enable only when R0 is writable.
    @(negedge clock); clear = 1'b1;
    @(negedge clock); clear = 1'b0;
    req_valid = 3'b001;
    req_addr[3:0] = 4'd0;
    #1;
    check("r0_rdy", 64'(rdy0), 64'b001);
    check("r0w_rdy", 64'(rdy1), 64'b001);
    @(negedge clock); req_valid = 3'b011; #1;
    check("r0_wr_en", 64'(en0), 64'd0);
    check("r0_wr_valid", 64'(vld0), 64'd0);
    check("r0_grant", 64'(gid0), 64'd0);
    check("r0_ptr_adv", 64'(rdy0), 64'b010);
    check("r0w_wr_en", 64'(en1), 64'h0001);
    check("r0w_wr_valid", 64'(vld1), 64'd1);
    @(negedge clock); req_valid = 3'b000; #1;
    check("r0_next_wr_en", 64'(en0), 64'h0020);

    // Stall holds off requester 2 for three cycles.
    @(negedge clock);
    req_valid = 3'b100;
    req_addr[11:8] = 4'd15;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i > 0) @(negedge clock);
      #1;
      check("stall_rdy", 64'(rdy0), 64'd0);
      check("stall_wr_en", 64'(en0), 64'd0);
    end
    @(negedge clock); stall = 1'b0; #1;
    check("unstall_rdy", 64'(rdy0), 64'b100);
    @(negedge clock); req_valid = 3'b000; #1;
    check("unstall_wr_en", 64'(en0), 64'h8000);
    check("unstall_grant", 64'(gid0), 64'd2);

    // Transfer at edge k, clear at edge k+1.
    @(negedge clock);
    req_valid = 3'b001;
    req_addr[3:0] = 4'd9;
    #1 check("clr_rdy", 64'(rdy0), 64'b001);
    @(negedge clock); req_valid = 3'b000; clear = 1'b1; #1;
    check("clr_inflight_wr_en", 64'(en0), 64'h0200);
    check("clr_rdy_held", 64'(rdy0), 64'd0);
    @(negedge clock); clear = 1'b0; req_valid = 3'b011; #1;
    check("clr_wr_en", 64'(en0), 64'd0);
    check("clr_wr_valid", 64'(vld0), 64'd0);
    check("clr_grant", 64'(gid0), 64'd0);
    check("clr_ptr_reset", 64'(rdy0), 64'b001);

    @(negedge clock); req_valid = 3'b000;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
